pipe_regfile: RTL and testbench
===============================

Name: pipe_regfile

Overview:
- Parametrised successor to the pipeline CPU's 32x32 register file: configurable data width, register count and number of read ports, plus a debug read port for the display unit.
- Writes occur on the rising edge. An optional same-cycle write-to-read bypass replaces the old negedge-write trick.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight writes. It sits between ID (read, issue) and WB (write).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count DEPTH = 2**ADDR_W
- NUM_RD, 2, number of architectural read ports (1..4)
- BYPASS, 1, 1 = a same-cycle WB write is forwarded to the read ports; 0 = reads return the stored value
- PEND_W, 2, width of each per-register in-flight-writer counter

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  synchronous reset, active high
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_busy  out  NUM_RD  1 = the addressed register has an outstanding writer
- wr_en  in  1  writeback enable (formerly L_S)
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  decode issued an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination register of the issued instruction
- flush  in  1  pipeline flush; discards all pending-writer counts
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (stored value, never bypassed)
- pend_err  out  1  sticky flag: scoreboard overflow or underflow

Behaviour:
- Reset (rising edge with rst=1):
  - all registers become 0, all counters become 0, pend_err becomes 0.
  - rst overrides wr_en, iss_en and flush in the same cycle.
- Register 0 is hardwired to zero:
  - reads of address 0 return 0.
  - writes to address 0 are ignored.
  - issue to address 0 is ignored; register 0 is never busy.
- Write: if wr_en=1 and wr_addr!=0, reg[wr_addr] takes wr_data at the rising edge. Write latency is 1 cycle.
- Read ports are combinational from the stored array.
  - With BYPASS=1, if wr_en=1, wr_addr==rd_addr[i] and the address is nonzero, rd_data[i] = wr_data in the same cycle.
  - dbg_data is always the stored value.
- Counter cnt[a] for each a!=0, with inc = iss_en & (iss_addr==a) and dec = wr_en & (wr_addr==a):
  - inc only: cnt+1. If cnt is already 2**PEND_W-1, cnt holds and pend_err is set.
  - dec only: cnt-1. If cnt==0, cnt holds and pend_err is NOT set; unscheduled writes (e.g. from the debug unit) are legal.
  - inc and dec together: cnt unchanged.
  - flush=1: every cnt goes to 0 at the edge, overriding inc/dec. The data write in that cycle still happens.
- rd_busy[i]:
  - = (cnt[rd_addr[i]]!=0) when BYPASS=0.
  - when BYPASS=1, forced to 0 if a same-cycle write to that address would bring cnt to 0, i.e. cnt==1, dec=1 and inc=0.
- pend_err is sticky until rst.
- No other state exists. All outputs are valid from the first cycle after reset.

Decomposition:
- Shared package rf_pkg holds:
  - default constants RF_DATA_W=32, RF_ADDR_W=5, RF_NUM_RD=2, RF_PEND_W=2
  - a function to slice a packed port index.
- One sub-module, rf_pend_ctr: a PEND_W-bit saturating up/down counter.
  - inputs: clk, rst, flush, inc, dec
  - outputs: busy, ovf
  - instantiated DEPTH-1 times via generate; the top-level ORs the ovf outputs into pend_err.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 and read r5 on port 0 the next cycle -> rd_data0=0xDEADBEEF, rd_busy0=0. Write to r0, then read r0 -> 0.
- BYPASS=1: wr_en=1, wr_addr=7, wr_data=0x1234 while rd_addr1=7 in the same cycle -> rd_data1=0x1234 that cycle. Repeat with BYPASS=0 -> old value (0) that cycle, 0x1234 the next.
- Scoreboard: issue r3 twice (cnt=2), write r3 once -> rd_busy=1. Write r3 again -> in that cycle rd_busy=0 (BYPASS=1), cnt=0 after the edge. Issue and write r3 in the same cycle -> cnt unchanged.
- Overflow: issue r9 four times with PEND_W=2 -> cnt saturates at 3 and pend_err=1 from the 4th edge. pend_err stays 1 until rst pulses.
- Flush: cnt[4]=2, then flush=1 with iss_en=1 to r4 and wr_en=1 writing 0x55 to r4 -> after the edge cnt[4]=0, reg[4]=0x55, pend_err=0.
- Reset mid-operation: rst=1 together with wr_en to r6 and iss_en to r6 -> after the edge reg[6]=0, busy=0, dbg_data for r6 = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the pipelined register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;
  localparam int unsigned RF_PEND_W = 2;

  // LSB position of port idx inside a packed bus of w-bit fields
  function automatic int unsigned port_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// Saturating in-flight-writer counter for one architectural register.
module rf_pend_ctr
  import rf_pkg::*;
#(
  parameter int unsigned PEND_W = RF_PEND_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic ovf
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt;
  logic              drain;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + PEND_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - PEND_W'(1);
    end
  end

  // A forwarded write that retires the last outstanding writer clears busy early
  assign drain = (BYPASS != 0) && (cnt == PEND_W'(1)) && dec && !inc;
  assign busy  = (cnt != '0) && !drain;
  assign ovf   = inc && !dec && !flush && (cnt == CNT_MAX);

endmodule

// File: rtl/pipe_regfile.sv
// Parametrised register file with write bypass and per-register pending-write scoreboard.
module pipe_regfile
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned PEND_W = RF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     pend_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  ovf_vec;

  // Storage; entry 0 is never written so it stays zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_err <= 1'b0;
    end else if (|ovf_vec) begin
      pend_err <= 1'b1;
    end
  end

  assign busy_vec[0] = 1'b0;
  assign ovf_vec[0]  = 1'b0;

  for (genvar a = 1; a < DEPTH; a++) begin : g_ctr
    rf_pend_ctr #(
      .PEND_W (PEND_W),
      .BYPASS (BYPASS)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .inc   (iss_en && (iss_addr == ADDR_W'(a))),
      .dec   (wr_en && (wr_addr == ADDR_W'(a))),
      .busy  (busy_vec[a]),
      .ovf   (ovf_vec[a])
    );
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra  = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == ra) && (ra != '0);
    assign rd_data[port_lsb(p, DATA_W) +: DATA_W] = (ra == '0) ? '0 :
                                                    hit        ? wr_data : mem[ra];
    assign rd_busy[p] = busy_vec[ra];
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_pipe_regfile.sv
// Scoreboard bench for pipe_regfile: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_pipe_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr, iss_addr, dbg_addr;
  logic wr_en, iss_en, flush;
  logic [DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;

  logic [NR*DW-1:0] a_rd_data, b_rd_data;
  logic [NR-1:0]    a_rd_busy, b_rd_busy;
  logic [DW-1:0]    a_dbg, b_dbg;
  logic             a_perr, b_perr;

  int checks = 0;
  int failures = 0;
  int sel_q[$];
  logic [31:0] exp_q[$];

  assign rd_addr = {rd_addr1, rd_addr0};

  always #5 clk = ~clk;

  pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .PEND_W(2)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(a_dbg), .pend_err(a_perr)
  );

  pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .PEND_W(2)) u_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(b_dbg), .pend_err(b_perr)
  );

  function automatic logic [31:0] actual(input int s);
    case (s)
      0:       return a_rd_data[31:0];
      1:       return a_rd_data[63:32];
      2:       return {31'b0, a_rd_busy[0]};
      3:       return {31'b0, a_rd_busy[1]};
      4:       return a_dbg;
      5:       return {31'b0, a_perr};
      6:       return b_rd_data[31:0];
      7:       return b_rd_data[63:32];
      8:       return {31'b0, b_rd_busy[0]};
      9:       return {31'b0, b_rd_busy[1]};
      10:      return b_dbg;
      11:      return {31'b0, b_perr};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic string sel_name(input int s);
    case (s)
      0:       return "byp_rd_data0";
      1:       return "byp_rd_data1";
      2:       return "byp_rd_busy0";
      3:       return "byp_rd_busy1";
      4:       return "byp_dbg_data";
      5:       return "byp_pend_err";
      6:       return "nobyp_rd_data0";
      7:       return "nobyp_rd_data1";
      8:       return "nobyp_rd_busy0";
      9:       return "nobyp_rd_busy1";
      10:      return "nobyp_dbg_data";
      11:      return "nobyp_pend_err";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every queued expectation against the live outputs mid-cycle
  always @(negedge clk) begin
    int s;
    logic [31:0] e;
    logic [31:0] act;
    while (sel_q.size() > 0) begin
      s   = sel_q.pop_front();
      e   = exp_q.pop_front();
      act = actual(s);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s actual=%h required=%h t=%0t", sel_name(s), act, e, $time);
      end
    end
  end

  task automatic push_exp(input int s, input logic [31:0] v);
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    idle(); iss_en = 1'b1; iss_addr = a;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [31:0] d);
    idle(); wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    rd_addr0 = '0; rd_addr1 = '0; wr_addr = '0; iss_addr = '0; dbg_addr = '0; wr_data = '0;
    tick();
    tick();

    // Reset state
    idle(); rd_addr0 = 5; dbg_addr = 5;
    push_exp(0, 0); push_exp(2, 0); push_exp(4, 0); push_exp(5, 0); push_exp(11, 0);
    tick();

    // Plain write then read
    write(5, 32'hDEAD_BEEF); rd_addr0 = 1;
    tick();
    idle(); rd_addr0 = 5;
    push_exp(0, 32'hDEAD_BEEF); push_exp(2, 0); push_exp(6, 32'hDEAD_BEEF); push_exp(4, 32'hDEAD_BEEF);
    tick();

    // Register 0 ignores writes and is never bypassed
    write(0, 32'hFFFF_FFFF); rd_addr0 = 0;
    push_exp(0, 0); push_exp(6, 0);
    tick();
    idle(); dbg_addr = 0;
    push_exp(0, 0); push_exp(4, 0); push_exp(2, 0);
    tick();

    // Same-cycle bypass versus stored value
    write(7, 32'h0000_1234); rd_addr1 = 7; dbg_addr = 7;
    push_exp(1, 32'h1234); push_exp(7, 0); push_exp(4, 0); push_exp(10, 0);
    tick();
    idle();
    push_exp(1, 32'h1234); push_exp(7, 32'h1234); push_exp(4, 32'h1234);
    tick();

    // Scoreboard on r3: two issues, then two writebacks
    issue(3); rd_addr0 = 3;
    push_exp(2, 0); push_exp(8, 0);
    tick();
    issue(3);
    push_exp(2, 1); push_exp(8, 1);
    tick();
    write(3, 32'h33);
    push_exp(2, 1); push_exp(8, 1); push_exp(0, 32'h33); push_exp(6, 0);
    tick();
    write(3, 32'h34);
    push_exp(2, 0); push_exp(8, 1);
    tick();
    idle();
    push_exp(2, 0); push_exp(8, 0); push_exp(0, 32'h34);
    tick();

    // Issue and write together leaves the count unchanged
    issue(3);
    tick();
    write(3, 32'h35); iss_en = 1'b1; iss_addr = 3;
    push_exp(2, 1); push_exp(8, 1);
    tick();
    idle();
    push_exp(2, 1); push_exp(8, 1); push_exp(0, 32'h35);
    tick();
    write(3, 32'h36);
    push_exp(2, 0); push_exp(8, 1);
    tick();
    idle();
    push_exp(2, 0); push_exp(8, 0); push_exp(5, 0); push_exp(11, 0);
    tick();

    // Flush clears counts but the write still lands
    issue(4); rd_addr0 = 4;
    tick();
    issue(4);
    tick();
    idle();
    push_exp(2, 1);
    tick();
    write(4, 32'h55); iss_en = 1'b1; iss_addr = 4; flush = 1'b1;
    push_exp(2, 1); push_exp(8, 1);
    tick();
    idle(); dbg_addr = 4;
    push_exp(2, 0); push_exp(8, 0); push_exp(0, 32'h55); push_exp(4, 32'h55);
    push_exp(5, 0); push_exp(11, 0);
    tick();

    // Overflow on r9: fourth issue saturates and sets the sticky error
    rd_addr1 = 9;
    for (int i = 0; i < 3; i++) begin
      issue(9);
      push_exp(5, 0);
      tick();
    end
    issue(9);
    push_exp(5, 0); push_exp(3, 1);
    tick();
    idle();
    push_exp(5, 1); push_exp(11, 1); push_exp(3, 1); push_exp(9, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      push_exp(5, 1);
      tick();
    end

    // Reset mid-operation overrides write and issue
    write(6, 32'h66);
    tick();
    write(6, 32'h77); iss_en = 1'b1; iss_addr = 6; rst = 1'b1;
    tick();
    idle(); rd_addr0 = 6; rd_addr1 = 5; dbg_addr = 6;
    push_exp(0, 0); push_exp(2, 0); push_exp(4, 0); push_exp(5, 0);
    push_exp(6, 0); push_exp(8, 0); push_exp(1, 0); push_exp(11, 0);
    tick();

    @(negedge clk);
    #1;
    if (sel_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sel_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
